// File: rtl/fifo_frame_reader_pkg.sv
// rtl/fifo_frame_reader_pkg.sv - shared constants for the ADC FIFO frame reader
package fifo_frame_reader_pkg;

  localparam int DEF_DATA_W         = 16;
  localparam int DEF_LEN_W          = 11;
  localparam int DEF_NUMBER_SAMPLES = 1024;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/fifo_frame_reader_axis_skid_buf.sv
// rtl/fifo_frame_reader_axis_skid_buf.sv - 2-entry registered AXIS output buffer with occupancy
module axis_skid_buf
  import fifo_frame_reader_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Push,
  input  logic [DATA_W-1:0] Push_Data,
  input  logic              Push_Last,
  output logic [DATA_W-1:0] M_Tdata,
  output logic              M_Tvalid,
  input  logic              M_Tready,
  output logic              M_Tlast,
  output logic [1:0]        Occupancy
);

  logic [DATA_W-1:0] sp_data;
  logic              sp_last;
  logic              sp_valid;
  logic              pop;

  assign pop       = M_Tvalid & M_Tready;
  assign Occupancy = {1'b0, M_Tvalid} + {1'b0, sp_valid};

  // Output register refills from the spare entry first so beat order is kept;
  // a push that cannot reach the output while it is stalled parks in the spare.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      M_Tdata  <= '0;
      M_Tvalid <= 1'b0;
      M_Tlast  <= 1'b0;
      sp_data  <= '0;
      sp_last  <= 1'b0;
      sp_valid <= 1'b0;
    end else if (!M_Tvalid || pop) begin
      if (sp_valid) begin
        M_Tdata  <= sp_data;
        M_Tlast  <= sp_last;
        M_Tvalid <= 1'b1;
        if (Push) begin
          sp_data <= Push_Data;
          sp_last <= Push_Last;
        end else begin
          sp_valid <= 1'b0;
        end
      end else if (Push) begin
        M_Tdata  <= Push_Data;
        M_Tlast  <= Push_Last;
        M_Tvalid <= 1'b1;
      end else begin
        M_Tvalid <= 1'b0;
      end
    end else if (Push) begin
      sp_data  <= Push_Data;
      sp_last  <= Push_Last;
      sp_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fifo_frame_reader.sv
// rtl/fifo_frame_reader.sv - ADC FIFO frame reader to AXI4-Stream; FRAME_HEADER_EN adds a sequence header beat
module fifo_frame_reader
  import fifo_frame_reader_pkg::*;
#(
  parameter int DATA_W         = DEF_DATA_W,
  parameter int LEN_W          = DEF_LEN_W,
  parameter int NUMBER_SAMPLES = DEF_NUMBER_SAMPLES
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  input  logic [LEN_W-1:0]  Frame_Len,
  input  logic [DATA_W-1:0] FIFO_Dout,
  input  logic              FIFO_Empty,
  output logic              FIFO_Rd_En,
  output logic [DATA_W-1:0] M_Tdata,
  output logic              M_Tvalid,
  input  logic              M_Tready,
  output logic              M_Tlast,
  output logic              Busy,
  output logic              Frame_Done
);

  localparam int CNT_W = LEN_W + 1;

  logic [1:0]        state;
  logic [CNT_W-1:0]  len;
  logic [CNT_W-1:0]  rd_cnt;
  logic [CNT_W-1:0]  tx_cnt;
  logic [CNT_W-1:0]  frame_beats;
  logic              inflight;
  logic              inflight_last;
  logic [1:0]        occupancy;
  logic [2:0]        slots_used;
  logic              pop;
  logic              hdr_push;
  logic              final_read;
  logic              final_beat;
  logic              push;
  logic [DATA_W-1:0] push_data;
  logic              push_last;

`ifdef FRAME_HEADER_EN
  logic              hdr_pend;
  logic [DATA_W-1:0] seq_cnt;

  assign hdr_push    = (state == ST_RUN) & hdr_pend;
  assign frame_beats = len + CNT_W'(1);
  assign push_data   = inflight ? FIFO_Dout : seq_cnt;

  // Header is owed from the accepted Start until it enters the buffer;
  // the sequence number advances once per completed frame.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      hdr_pend <= 1'b0;
      seq_cnt  <= '0;
    end else begin
      if (state == ST_IDLE && Start) begin
        hdr_pend <= 1'b1;
      end else if (hdr_push) begin
        hdr_pend <= 1'b0;
      end
      if (state == ST_DONE) begin
        seq_cnt <= seq_cnt + 1'b1;
      end
    end
  end
`else
  assign hdr_push    = 1'b0;
  assign frame_beats = len;
  assign push_data   = FIFO_Dout;
`endif

  assign pop = M_Tvalid & M_Tready;

  // A beat leaving this cycle frees its slot, so it is credited here; that is
  // what lets a read go out every cycle while the stream is flowing.
  assign slots_used = {1'b0, occupancy} + {2'b0, inflight} + {2'b0, hdr_push} - {2'b0, pop};

  assign FIFO_Rd_En = (state == ST_RUN) & ~FIFO_Empty & (rd_cnt < len) & (slots_used < 3'd2);
  assign final_read = FIFO_Rd_En & (rd_cnt == len - CNT_W'(1));
  assign final_beat = pop & (tx_cnt == frame_beats - CNT_W'(1));

  assign push      = inflight | hdr_push;
  assign push_last = inflight & inflight_last;

  assign Busy       = (state == ST_RUN) | (state == ST_DRAIN);
  assign Frame_Done = (state == ST_DONE);

  // Frame sequencing, read/beat counters and the one-cycle FIFO return tracker.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state         <= ST_IDLE;
      len           <= '0;
      rd_cnt        <= '0;
      tx_cnt        <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= FIFO_Rd_En;
      inflight_last <= final_read;
      if (FIFO_Rd_En) begin
        rd_cnt <= rd_cnt + 1'b1;
      end
      if (pop) begin
        tx_cnt <= tx_cnt + 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (Start) begin
            len    <= (Frame_Len == '0) ? CNT_W'(NUMBER_SAMPLES) : {1'b0, Frame_Len};
            rd_cnt <= '0;
            tx_cnt <= '0;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (final_read) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (final_beat) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  axis_skid_buf #(
    .DATA_W (DATA_W)
  ) u_skid (
    .Clk       (Clk),
    .Rst       (Rst),
    .Push      (push),
    .Push_Data (push_data),
    .Push_Last (push_last),
    .M_Tdata   (M_Tdata),
    .M_Tvalid  (M_Tvalid),
    .M_Tready  (M_Tready),
    .M_Tlast   (M_Tlast),
    .Occupancy (occupancy)
  );

endmodule

// File: tb/tb_fifo_frame_reader.sv
// tb/tb_fifo_frame_reader.sv - self-checking bench for fifo_frame_reader (FRAME_HEADER_EN aware)
module tb_fifo_frame_reader;

  localparam int DATA_W = 16;
  localparam int LEN_W  = 11;
`ifdef FRAME_HEADER_EN
  localparam int EXTRA = 1;
  localparam int LAT   = 1;
`else
  localparam int EXTRA = 0;
  localparam int LAT   = 2;
`endif

  logic              Clk = 1'b0;
  logic              Rst = 1'b1;
  logic              Start = 1'b0;
  logic [LEN_W-1:0]  Frame_Len = '0;
  logic [DATA_W-1:0] FIFO_Dout = '0;
  logic              FIFO_Empty;
  logic              FIFO_Rd_En;
  logic [DATA_W-1:0] M_Tdata;
  logic              M_Tvalid;
  logic              M_Tready = 1'b0;
  logic              M_Tlast;
  logic              Busy;
  logic              Frame_Done;

  int n_vec = 0;
  int n_err = 0;

  fifo_frame_reader dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Start      (Start),
    .Frame_Len  (Frame_Len),
    .FIFO_Dout  (FIFO_Dout),
    .FIFO_Empty (FIFO_Empty),
    .FIFO_Rd_En (FIFO_Rd_En),
    .M_Tdata    (M_Tdata),
    .M_Tvalid   (M_Tvalid),
    .M_Tready   (M_Tready),
    .M_Tlast    (M_Tlast),
    .Busy       (Busy),
    .Frame_Done (Frame_Done)
  );

  always #5 Clk = ~Clk;

  // Standard-mode FIFO: data appears the cycle after the read strobe
  logic [DATA_W-1:0] fifo_mem [0:4095];
  logic [11:0]       wr_ptr = '0;
  logic [11:0]       rd_ptr = '0;
  int                rd_total = 0;
  logic              flush_req = 1'b0;
  logic [DATA_W-1:0] model_fifo [$];

  assign FIFO_Empty = (rd_ptr == wr_ptr);

  always @(posedge Clk) begin
    if (FIFO_Rd_En) rd_total <= rd_total + 1;
    if (flush_req) begin
      rd_ptr <= wr_ptr;
    end else if (FIFO_Rd_En && (rd_ptr != wr_ptr)) begin
      FIFO_Dout <= fifo_mem[rd_ptr];
      rd_ptr    <= rd_ptr + 12'd1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Frame-level model: which word must come next, when Busy/Frame_Done must be high
  bit                m_busy = 0;
  bit                m_done = 0;
  bit                m_hdr = 0;
  int                m_remaining = 0;
  int                m_seq = 0;
  bit                prev_stall = 0;
  logic [DATA_W-1:0] prev_data;
  logic              prev_last;
  int                cyc = 0;
  int                done_cnt = 0;
  int                fr_beats = 0;
  int                fr_tlast_cnt = 0;
  int                fr_first_cyc = -1;
  int                fr_last_cyc = -1;
  int                fr_first_rd = -1;
  int                fr_first_valid = -1;
  logic [DATA_W-1:0] fr_first_data;
  logic [DATA_W-1:0] fr_last_data;

  // Compare process: every cycle, DUT outputs against the model
  always @(negedge Clk) begin
    logic [DATA_W-1:0] e_data;
    logic              e_last;
    bit                hs_final;
    bit                accept;
    bit                have_exp;
    cyc++;
    if (Rst) begin
      chk("rst_rd_en", {31'd0, FIFO_Rd_En}, 0);
      chk("rst_tvalid", {31'd0, M_Tvalid}, 0);
      chk("rst_tlast", {31'd0, M_Tlast}, 0);
      chk("rst_tdata", {16'd0, M_Tdata}, 0);
      chk("rst_busy", {31'd0, Busy}, 0);
      chk("rst_done", {31'd0, Frame_Done}, 0);
      m_busy = 0; m_done = 0; m_hdr = 0; m_remaining = 0; m_seq = 0; prev_stall = 0;
    end else begin
      chk("busy", {31'd0, Busy}, {31'd0, m_busy});
      chk("frame_done", {31'd0, Frame_Done}, {31'd0, m_done});
      if (Frame_Done) done_cnt++;
      if (prev_stall) begin
        chk("hold_tvalid", {31'd0, M_Tvalid}, 1);
        chk("hold_tdata", {16'd0, M_Tdata}, {16'd0, prev_data});
        chk("hold_tlast", {31'd0, M_Tlast}, {31'd0, prev_last});
      end
      if (FIFO_Rd_En) begin
        chk("rd_on_empty", {31'd0, FIFO_Empty}, 0);
        if (fr_first_rd < 0) fr_first_rd = cyc;
      end
      if (M_Tvalid && fr_first_valid < 0) fr_first_valid = cyc;
      hs_final = 0;
      if (M_Tvalid && M_Tready) begin
        have_exp = 1;
        e_data = '0;
        e_last = 1'b0;
        if (m_hdr) begin
          e_data = m_seq[DATA_W-1:0];
          m_hdr = 0;
        end else if (m_remaining > 0 && model_fifo.size() > 0) begin
          e_data = model_fifo.pop_front();
          e_last = (m_remaining == 1);
          m_remaining--;
        end else begin
          have_exp = 0;
          n_vec++;
          n_err++;
          $display("FAIL beat_unexpected actual=beat %0h required=no beat", M_Tdata);
        end
        if (have_exp) begin
          chk("tdata", {16'd0, M_Tdata}, {16'd0, e_data});
          chk("tlast", {31'd0, M_Tlast}, {31'd0, e_last});
          hs_final = e_last;
        end
        if (fr_beats == 0) begin
          fr_first_cyc  = cyc;
          fr_first_data = M_Tdata;
        end
        fr_beats++;
        fr_last_cyc  = cyc;
        fr_last_data = M_Tdata;
        if (M_Tlast) fr_tlast_cnt++;
      end
      if (m_done) m_seq++;
      accept = !m_busy && !m_done && Start;
      m_done = hs_final;
      if (accept) begin
        m_busy = 1;
        m_remaining = (Frame_Len == 0) ? 1024 : int'(Frame_Len);
`ifdef FRAME_HEADER_EN
        m_hdr = 1;
`endif
        fr_beats = 0; fr_tlast_cnt = 0; fr_first_cyc = -1; fr_last_cyc = -1;
        fr_first_rd = -1; fr_first_valid = -1;
      end else if (hs_final) begin
        m_busy = 0;
      end
      prev_stall = M_Tvalid && !M_Tready;
      prev_data  = M_Tdata;
      prev_last  = M_Tlast;
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic fifo_push(input logic [DATA_W-1:0] w);
    fifo_mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 12'd1;
    model_fifo.push_back(w);
  endtask

  task automatic flush();
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    model_fifo.delete();
  endtask

  task automatic start_frame(input int len);
    Frame_Len = LEN_W'(len);
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic wait_done(input int bound, input string name);
    bit seen = 0;
    for (int i = 0; i < bound && !seen; i++) begin
      tick();
      if (Frame_Done) seen = 1;
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout actual=no Frame_Done required=Frame_Done within %0d cycles", name, bound);
    end
    tick();
  endtask

  task automatic wait_beats(input int n, input int bound, input string name);
    bit seen = 0;
    for (int i = 0; i < bound && !seen; i++) begin
      tick();
      if (fr_beats >= n) seen = 1;
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout actual=%0d beats required=%0d beats", name, fr_beats, n);
    end
  endtask

  initial begin
    int rd0;
    int dc0;
    int st;
    bit seen;

    tick(); tick();
    chk("reset_tvalid", {31'd0, M_Tvalid}, 0);
    chk("reset_busy", {31'd0, Busy}, 0);
    Rst = 1'b0;
    M_Tready = 1'b1;
    tick();

    // 8-sample frame at full rate
    for (int i = 0; i < 8; i++) fifo_push(DATA_W'(i));
    start_frame(8);
    wait_done(100, "t1");
    chk("t1_beats", fr_beats, 8 + EXTRA);
    chk("t1_last_data", {16'd0, fr_last_data}, 7);
    chk("t1_tlast_cnt", fr_tlast_cnt, 1);
    chk("t1_back_to_back", fr_last_cyc - fr_first_cyc, 7 + EXTRA);
    chk("t1_first_latency", fr_first_valid - fr_first_rd, LAT);
    chk("t1_busy_after", {31'd0, Busy}, 0);

    // Frame_Len=0 selects 1024 samples; the rest stay in the FIFO
    for (int i = 0; i < 1100; i++) fifo_push(DATA_W'(16'h1000 + i));
    rd0 = rd_total;
    start_frame(0);
    wait_done(1500, "t2");
    chk("t2_beats", fr_beats, 1024 + EXTRA);
    chk("t2_reads", rd_total - rd0, 1024);
    chk("t2_left_in_fifo", {20'd0, wr_ptr - rd_ptr}, 76);
    chk("t2_last_data", {16'd0, fr_last_data}, 16'h1000 + 1023);
    flush();

    // 16 samples with alternating ready plus a 5-cycle stall
    for (int i = 0; i < 16; i++) fifo_push(DATA_W'(16'h200 + i));
    st = $urandom_range(6, 20);
    start_frame(16);
    seen = 0;
    for (int c = 0; c < 400 && !seen; c++) begin
      M_Tready = ((c >= st) && (c < st + 5)) ? 1'b0 : c[0];
      tick();
      if (Frame_Done) seen = 1;
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL t3_timeout actual=no Frame_Done required=Frame_Done within 400 cycles");
    end
    M_Tready = 1'b1;
    tick();
    chk("t3_beats", fr_beats, 16 + EXTRA);
    chk("t3_last_data", {16'd0, fr_last_data}, 16'h20f);

    // FIFO underrun after word 3; mid-frame Start must be ignored
    dc0 = done_cnt;
    for (int i = 0; i < 4; i++) fifo_push(DATA_W'(16'h300 + i));
    start_frame(8);
    wait_beats(4 + EXTRA, 50, "t4_first_half");
    for (int i = 0; i < 10; i++) begin
      Start = (i == 3);
      Frame_Len = LEN_W'(3);
      tick();
    end
    Start = 1'b0;
    chk("t4_gap_tvalid", {31'd0, M_Tvalid}, 0);
    chk("t4_gap_busy", {31'd0, Busy}, 1);
    for (int i = 4; i < 8; i++) fifo_push(DATA_W'(16'h300 + i));
    wait_done(100, "t4");
    for (int i = 0; i < 5; i++) tick();
    chk("t4_done_pulses", done_cnt - dc0, 1);
    chk("t4_beats", fr_beats, 8 + EXTRA);
    chk("t4_last_data", {16'd0, fr_last_data}, 16'h307);

    // Reset mid-frame, then a fresh frame
    for (int i = 0; i < 8; i++) fifo_push(DATA_W'(16'h600 + i));
    start_frame(8);
    wait_beats(5, 50, "t5_partial");
    Rst = 1'b1;
    #1;
    chk("t5_async_tvalid", {31'd0, M_Tvalid}, 0);
    chk("t5_async_tdata", {16'd0, M_Tdata}, 0);
    chk("t5_async_busy", {31'd0, Busy}, 0);
    chk("t5_async_rd_en", {31'd0, FIFO_Rd_En}, 0);
    tick(); tick(); tick();
    Rst = 1'b0;
    tick();
    flush();
    for (int i = 0; i < 8; i++) fifo_push(DATA_W'(16'h700 + i));
    start_frame(8);
    wait_done(100, "t5");
    chk("t5_beats", fr_beats, 8 + EXTRA);
    chk("t5_last_data", {16'd0, fr_last_data}, 16'h707);

    // Two 4-sample frames from a clean reset (header numbers 0 and 1 when enabled)
    Rst = 1'b1;
    tick(); tick();
    Rst = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) fifo_push(DATA_W'(16'h800 + i));
    start_frame(4);
    wait_done(100, "t6a");
    chk("t6a_beats", fr_beats, 4 + EXTRA);
`ifdef FRAME_HEADER_EN
    chk("t6a_first", {16'd0, fr_first_data}, 0);
`else
    chk("t6a_first", {16'd0, fr_first_data}, 16'h800);
`endif
    chk("t6a_last_data", {16'd0, fr_last_data}, 16'h803);
    start_frame(4);
    wait_done(100, "t6b");
    chk("t6b_beats", fr_beats, 4 + EXTRA);
`ifdef FRAME_HEADER_EN
    chk("t6b_first", {16'd0, fr_first_data}, 1);
`else
    chk("t6b_first", {16'd0, fr_first_data}, 16'h804);
`endif
    chk("t6b_last_data", {16'd0, fr_last_data}, 16'h807);
    chk("t6_tlast_cnt", fr_tlast_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
